// File: rtl/router_pkt_src.sv
// Packet source for the router input port: buffers one request plus its payload,
// then plays header/payload/parity into the router and reports the err window result.
module router_pkt_src #(
  parameter int ERR_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [1:0]       req_addr,
  input  logic [5:0]       req_len,
  output logic             req_ready,
  input  logic             pl_valid,
  input  logic [7:0]       pl_data,
  output logic             pl_ready,
  output logic             pkt_valid,
  output logic [7:0]       data_out,
  input  logic             busy,
  input  logic             err,
  output logic             tx_done,
  output logic             tx_err,
  output logic             req_reject,
  output logic [CNT_W-1:0] pkt_cnt
);
  localparam int EW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
  localparam logic [EW-1:0] ELAST = EW'(ERR_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_HDR, S_PAY, S_PAR, S_EWAIT
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      addr_q;
  logic [5:0]      len_q;
  logic [5:0]      cnt;
  logic [7:0]      par;
  logic [EW-1:0]   ecnt;
  logic            errseen;
  logic [7:0]      mem [64];
  logic            xfer, pl_acc, last_pl, ecnt_last;

  assign last_pl   = (cnt == len_q - 6'd1);
  assign ecnt_last = (ecnt == ELAST);
  assign pl_acc    = pl_valid & pl_ready;

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    xfer      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = (req_addr == 2'd3 || req_len == 6'd0) ? S_DRAIN : S_LOAD;
      end
      S_LOAD: begin
        pl_ready = 1'b1;
        if (pl_valid && last_pl) state_nx = S_HDR;
      end
      S_DRAIN: begin
        pl_ready = (len_q != 6'd0);
        if (len_q == 6'd0)             state_nx = S_IDLE;
        else if (pl_valid && last_pl)  state_nx = S_IDLE;
      end
      S_HDR: begin
        xfer = ~busy;
        if (!busy) state_nx = S_PAY;
      end
      S_PAY: begin
        xfer = ~busy;
        if (!busy && last_pl) state_nx = S_PAR;
      end
      S_PAR: begin
        xfer = ~busy;
        if (!busy) state_nx = S_EWAIT;
      end
      S_EWAIT: begin
        if (ecnt_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // data_out/pkt_valid are registered and only move on a transfer or on HDR entry,
  // so a busy stall holds them without extra logic.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      par        <= '0;
      ecnt       <= '0;
      errseen    <= 1'b0;
      pkt_valid  <= 1'b0;
      data_out   <= '0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      req_reject <= 1'b0;
      pkt_cnt    <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      req_reject <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q <= req_addr;
          len_q  <= req_len;
          par    <= {req_len, req_addr};
          cnt    <= '0;
        end
        S_LOAD: if (pl_acc) begin
          mem[cnt] <= pl_data;
          par      <= par ^ pl_data;
          cnt      <= cnt + 6'd1;
          if (last_pl) begin
            pkt_valid <= 1'b1;
            data_out  <= {len_q, addr_q};
          end
        end
        S_DRAIN: begin
          if (pl_acc) cnt <= cnt + 6'd1;
          if (state_nx == S_IDLE) req_reject <= 1'b1;
        end
        S_HDR: if (xfer) begin
          cnt      <= '0;
          data_out <= mem[0];
        end
        S_PAY: if (xfer) begin
          if (last_pl) begin
            pkt_valid <= 1'b0;
            data_out  <= par;
          end else begin
            cnt      <= cnt + 6'd1;
            data_out <= mem[cnt + 6'd1];
          end
        end
        S_PAR: if (xfer) begin
          data_out <= '0;
          ecnt     <= '0;
          errseen  <= 1'b0;
        end
        S_EWAIT: begin
          errseen <= errseen | err;
          ecnt    <= ecnt + EW'(1);
          if (ecnt_last) begin
            tx_done <= 1'b1;
            tx_err  <= errseen | err;
            pkt_cnt <= pkt_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: table of packets with stall/err patterns,
// plus hand sequences for rejects, a 63-byte packet, counter wrap and mid-packet reset.
module tb_router_pkt_src;
  localparam int EWAIT = 3;
  localparam int CW    = 3;

  logic          clock = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready;
  logic [1:0]    req_addr;
  logic [5:0]    req_len;
  logic          pl_valid, pl_ready;
  logic [7:0]    pl_data;
  logic          pkt_valid;
  logic [7:0]    data_out;
  logic          busy, err;
  logic          tx_done, tx_err, req_reject;
  logic [CW-1:0] pkt_cnt;

  router_pkt_src #(.ERR_WAIT(EWAIT), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
    .pkt_valid(pkt_valid), .data_out(data_out), .busy(busy), .err(err),
    .tx_done(tx_done), .tx_err(tx_err), .req_reject(req_reject), .pkt_cnt(pkt_cnt)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [7:0] pl_bytes [64];

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    logic [7:0] b0, b1, b2, b3;
    int         hdr_busy;   // stall cycles on the header
    int         busy_idx;   // stream index (0=hdr) that gets busy_n stall cycles
    int         busy_n;
    int         err_cyc;    // EWAIT cycle (1..EWAIT) with err=1, 0 = none
    bit         early_err;  // err=1 while parity is still on the bus
    logic [7:0] exp_hdr, exp_par;
    bit         exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_req(input logic [1:0] a, input logic [5:0] l, input bit gaps,
                          input string name);
    int acc, guard;
    bit tog;
    @(negedge clock);
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_len = l;
    @(negedge clock);
    req_valid = 1'b0;
    acc = 0; guard = 0; tog = 1'b0;
    while (acc < int'(l) && guard < 400) begin
      if (gaps && tog) pl_valid = 1'b0;
      else begin pl_valid = 1'b1; pl_data = pl_bytes[acc]; end
      tog = !tog;
      if (pl_valid && pl_ready) acc++;
      @(negedge clock);
      guard++;
    end
    pl_valid = 1'b0;
    check({name, " bytes loaded"}, 32'(acc), 32'(l));
  endtask

  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input int hdr_busy,
                         input int busy_idx, input int busy_n, input int err_cyc,
                         input bit early_err, input bit gaps, input logic [7:0] exp_hdr,
                         input logic [7:0] exp_par, input bit exp_err, input string name);
    int j, stall, guard;
    bit done, bsy, ev;
    logic [7:0] ed;
    load_req(a, l, gaps, name);
    j = 0; stall = 0; guard = 0; done = 1'b0;
    while (!done && guard < 400) begin
      if (j == 0)          begin ev = 1'b1; ed = exp_hdr; end
      else if (j <= int'(l)) begin ev = 1'b1; ed = pl_bytes[j-1]; end
      else                 begin ev = 1'b0; ed = exp_par; end
      check($sformatf("%s byte%0d data", name, j), 32'(data_out), 32'(ed));
      check($sformatf("%s byte%0d pkt_valid", name, j), 32'(pkt_valid), 32'(ev));
      bsy = (j == 0 && stall < hdr_busy) || (j == busy_idx && stall < busy_n);
      busy = bsy;
      err = (early_err && j == int'(l) + 1);
      if (bsy) stall++;
      else begin
        stall = 0;
        if (j == int'(l) + 1) done = 1'b1;
        j++;
      end
      @(negedge clock);
      guard++;
    end
    busy = 1'b0; err = 1'b0;
    check({name, " stream completed"}, 32'(done), 32'd1);
    for (int c = 1; c <= EWAIT; c++) begin
      err = (c == err_cyc);
      check($sformatf("%s tx_done low in ewait%0d", name, c), 32'(tx_done), 32'd0);
      @(negedge clock);
    end
    err = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    check({name, " tx_done"}, 32'(tx_done), 32'd1);
    check({name, " tx_err"}, 32'(tx_err), 32'(exp_err));
    check({name, " pkt_cnt"}, 32'(pkt_cnt), 32'(exp_cnt));
    @(negedge clock);
    check({name, " tx_done one cycle"}, 32'(tx_done), 32'd0);
  endtask

  task automatic run_reject(input logic [1:0] a, input logic [5:0] l, input int exp_bytes,
                            input string name);
    int acc;
    bit seen, pv_seen;
    @(negedge clock);
    req_valid = 1'b1; req_addr = a; req_len = l;
    @(negedge clock);
    req_valid = 1'b0;
    acc = 0; seen = 1'b0; pv_seen = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      pl_valid = 1'b1; pl_data = 8'(8'hE0 + g);
      if (pkt_valid) pv_seen = 1'b1;
      if (req_reject) seen = 1'b1;
      else begin
        if (pl_ready) acc++;
        @(negedge clock);
      end
    end
    pl_valid = 1'b0;
    check({name, " bytes drained"}, 32'(acc), 32'(exp_bytes));
    check({name, " req_reject"}, 32'(seen), 32'd1);
    check({name, " pkt_valid never"}, 32'(pv_seen), 32'd0);
    check({name, " pkt_cnt kept"}, 32'(pkt_cnt), 32'(exp_cnt));
    @(negedge clock);
    check({name, " req_reject one cycle"}, 32'(req_reject), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // parity is the XOR of header and payload, e.g. 0x0D^0x11^0x22^0x33 = 0x0D
    vecs[0] = '{2'd1, 6'd3, 8'h11, 8'h22, 8'h33, 8'h00, 0, -1, 0, 0, 1'b0, 8'h0D, 8'h0D, 1'b0};
    vecs[1] = '{2'd1, 6'd3, 8'h11, 8'h22, 8'h33, 8'h00, 2,  2, 3, 0, 1'b0, 8'h0D, 8'h0D, 1'b0};
    vecs[2] = '{2'd0, 6'd1, 8'hA5, 8'h00, 8'h00, 8'h00, 0, -1, 0, 0, 1'b0, 8'h04, 8'hA1, 1'b0};
    vecs[3] = '{2'd2, 6'd2, 8'hFF, 8'h01, 8'h00, 8'h00, 0,  3, 1, 0, 1'b0, 8'h0A, 8'hF4, 1'b0};
    vecs[4] = '{2'd2, 6'd1, 8'h3C, 8'h00, 8'h00, 8'h00, 0, -1, 0, 2, 1'b0, 8'h06, 8'h3A, 1'b1};
    vecs[5] = '{2'd1, 6'd4, 8'h01, 8'h02, 8'h04, 8'h08, 0, -1, 0, 0, 1'b1, 8'h11, 8'h1E, 1'b0};
    vecs[6] = '{2'd0, 6'd2, 8'h80, 8'h40, 8'h00, 8'h00, 0, -1, 0, 3, 1'b0, 8'h08, 8'hC8, 1'b1};

    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0; err = 1'b0;
    #12;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset pl_ready", 32'(pl_ready), 32'd0);
    check("reset pkt_valid", 32'(pkt_valid), 32'd0);
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset pulses", {29'd0, tx_done, tx_err, req_reject}, 32'd0);
    check("reset pkt_cnt", 32'(pkt_cnt), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      pl_bytes[0] = vecs[v].b0; pl_bytes[1] = vecs[v].b1;
      pl_bytes[2] = vecs[v].b2; pl_bytes[3] = vecs[v].b3;
      run_pkt(vecs[v].addr, vecs[v].len, vecs[v].hdr_busy, vecs[v].busy_idx, vecs[v].busy_n,
              vecs[v].err_cyc, vecs[v].early_err, 1'b0, vecs[v].exp_hdr, vecs[v].exp_par,
              vecs[v].exp_err, $sformatf("vec%0d", v));
    end

    run_reject(2'd3, 6'd2, 2, "reject addr3");
    run_reject(2'd0, 6'd0, 0, "reject len0");

    // 63 bytes 1..63 XOR to 0, so parity equals the header 0xFE
    for (int i = 0; i < 63; i++) pl_bytes[i] = 8'(i + 1);
    run_pkt(2'd2, 6'd63, 0, -1, 0, 0, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0, "len63");
    check("pkt_cnt wrapped to 0", 32'(pkt_cnt), 32'd0);

    // reset while the 5th payload byte is on the bus
    for (int i = 0; i < 10; i++) pl_bytes[i] = 8'(8'h50 + i);
    load_req(2'd0, 6'd10, 1'b0, "midreset");
    for (int k = 0; k < 5; k++) @(negedge clock);
    check("midreset byte5 on bus", {23'd0, pkt_valid, data_out}, {23'd0, 1'b1, 8'h54});
    #2 resetn = 1'b0;
    #1;
    check("midreset pkt_valid", 32'(pkt_valid), 32'd0);
    check("midreset data_out", 32'(data_out), 32'd0);
    check("midreset req_ready", 32'(req_ready), 32'd1);
    check("midreset pl_ready", 32'(pl_ready), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    exp_cnt = '0;
    pl_bytes[0] = 8'h11; pl_bytes[1] = 8'h22; pl_bytes[2] = 8'h33;
    run_pkt(2'd1, 6'd3, 0, -1, 0, 0, 1'b0, 1'b0, 8'h0D, 8'h0D, 1'b0, "after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
